// File: rtl/tmds_pkg.sv
// Shared types for the TMDS video controller: pixel layout, per-channel ctrl, FSM states.
package tmds_pkg;

  localparam int NUM_CH = 3;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef logic [1:0] ctrl_t;

  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

  function automatic int cnt_w(input int m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/tmds_video_ctrl_if.sv
// Upstream pixel stream into the controller; the source drives rgb/valid, the controller pops with ready.
interface tmds_video_ctrl_if;
  import tmds_pkg::*;

  rgb_t in_rgb;
  logic in_valid;
  logic in_ready;

  modport master (output in_rgb, in_valid, input in_ready);
  modport slave  (input in_rgb, in_valid, output in_ready);
endinterface

// File: rtl/tmds_wrap_counter.sv
// Modulo-MOD up counter; wrap is high on the enabled cycle that returns the count to 0.
module tmds_wrap_counter
  import tmds_pkg::*;
#(
  parameter int MOD = 8,
  localparam int W = cnt_w(MOD)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  assign wrap = en && (cnt == W'(MOD - 1));

  always_ff @(posedge clk) begin
    if (!rst_n)  cnt <= '0;
    else if (en) cnt <= wrap ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/tmds_video_ctrl.sv
// Raster timing generator feeding three TMDS encoders; pops upstream pixels in the active region.
// Optional underflow_cnt output when TMDS_VIDEO_CTRL_UFCNT_EN is defined.
module tmds_video_ctrl
  import tmds_pkg::*;
#(
  parameter int          H_ACTIVE = 640,
  parameter int          H_FP     = 16,
  parameter int          H_SYNC   = 96,
  parameter int          H_BP     = 48,
  parameter int          V_ACTIVE = 480,
  parameter int          V_FP     = 10,
  parameter int          V_SYNC   = 2,
  parameter int          V_BP     = 33,
  parameter logic        HS_POL   = 1'b0,
  parameter logic        VS_POL   = 1'b0,
  parameter logic [23:0] IDLE_RGB = 24'h000000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  tmds_video_ctrl_if.slave         pix,
  output logic [NUM_CH-1:0][7:0]   enc_data,
  output ctrl_t [NUM_CH-1:0]       enc_ctrl,
  output logic                     enc_active,
  output logic                     frame_start,
  output logic                     underflow,
  input  logic                     underflow_clr
`ifdef TMDS_VIDEO_CTRL_UFCNT_EN
  ,
  output logic [15:0]              underflow_cnt
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = cnt_w(H_TOTAL);
  localparam int VW      = cnt_w(V_TOTAL);
  localparam int HS_BEG  = H_ACTIVE + H_FP;
  localparam int VS_BEG  = V_ACTIVE + V_FP;
  localparam ctrl_t SYNC_OFF = {~VS_POL, ~HS_POL};

  state_t          state, nxt;
  logic            run;
  logic            h_wrap, last;
  logic [HW-1:0]   h;
  logic [VW-1:0]   v;
  logic            act, hs, vs, slot, uf_set;
  logic [NUM_CH-1:0][7:0] src, idle_px, data_nxt;

  tmds_wrap_counter #(.MOD(H_TOTAL)) u_h (
    .clk(clk), .rst_n(rst_n), .en(run), .cnt(h), .wrap(h_wrap)
  );

  // v advances on the line wrap, so its own wrap marks the last clock of the frame.
  tmds_wrap_counter #(.MOD(V_TOTAL)) u_v (
    .clk(clk), .rst_n(rst_n), .en(h_wrap), .cnt(v), .wrap(last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:     if (en) nxt = RUN;
      RUN:      if (!en) nxt = STOPPING;
      STOPPING: if (en) nxt = RUN;
                else if (last) nxt = IDLE;
      default:  nxt = IDLE;
    endcase
  end

  always_comb begin
    run          = (state != IDLE);
    pix.in_ready = run && act;
  end

  assign act    = (int'(h) < H_ACTIVE) && (int'(v) < V_ACTIVE);
  assign hs     = (int'(h) >= HS_BEG) && (int'(h) < HS_BEG + H_SYNC);
  assign vs     = (int'(v) >= VS_BEG) && (int'(v) < VS_BEG + V_SYNC);
  assign slot   = run && act;
  assign uf_set = slot && !pix.in_valid;

  assign src     = pix.in_rgb;
  assign idle_px = IDLE_RGB;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    assign data_nxt[ch] = !slot        ? 8'h00 :
                          pix.in_valid ? src[ch] : idle_px[ch];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      enc_data    <= '0;
      enc_ctrl    <= '0;
      enc_ctrl[0] <= SYNC_OFF;
      enc_active  <= 1'b0;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      enc_data    <= data_nxt;
      enc_ctrl    <= '0;
      enc_ctrl[0] <= {(run && vs) ? VS_POL : ~VS_POL, (run && hs) ? HS_POL : ~HS_POL};
      enc_active  <= slot;
      frame_start <= run && (h == '0) && (v == '0);
      // A fresh underflow outranks a same-cycle clear.
      if (uf_set)             underflow <= 1'b1;
      else if (underflow_clr) underflow <= 1'b0;
    end
  end

`ifdef TMDS_VIDEO_CTRL_UFCNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n)                                underflow_cnt <= '0;
    else if (underflow_clr)                    underflow_cnt <= {15'd0, uf_set};
    else if (uf_set && underflow_cnt != 16'hFFFF) underflow_cnt <= underflow_cnt + 16'd1;
  end
`endif

endmodule
